// File: rtl/lmg_pkg.sv
// Shared types and constants for the LMG sequencer and its helpers.
package lmg_pkg;

    localparam int unsigned MOVE_W         = 19;
    localparam int unsigned SLOTS          = 8;
    localparam int unsigned WORD_W         = 160;
    localparam int unsigned MV_INVALID_BIT = 18;
    localparam int unsigned SLOT_IDX_W     = 3;

    // Move field layout
    localparam int unsigned SQ_W     = 6;
    localparam int unsigned TO_LSB   = 0;
    localparam int unsigned FROM_LSB = 6;
    localparam int unsigned PASS_LSB = 12;
    localparam int unsigned PASS_W   = 6;

    typedef logic [MOVE_W-1:0]                move_t;
    // Slot 1 occupies the top of the payload, so it sits at index SLOTS-1.
    typedef logic [SLOTS-1:0][MOVE_W-1:0]     slots_t;
    typedef logic [SLOT_IDX_W-1:0]            slot_idx_t;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitDone,
        StPop,
        StCapture,
        StEmit,
        StFinish
    } state_t;

    // Zero-based slot index (0 = slot 1) to move; index is mirrored.
    function automatic move_t slot_get(input slots_t s, input slot_idx_t idx);
        return s[~idx];
    endfunction

endpackage

// File: rtl/lmg_seq_if.sv
// Move stream from the sequencer to the search engine.
interface lmg_seq_if;
    import lmg_pkg::*;

    logic  mv_valid;
    move_t mv_data;
    logic  mv_ready;

    modport master (output mv_valid, output mv_data, input mv_ready);
    modport slave  (input mv_valid, input mv_data, output mv_ready);
endinterface

// File: rtl/lmg_slot_pick.sv
// Lowest-set-bit priority select over the slot mask.
module lmg_slot_pick
    import lmg_pkg::*;
(
    input  logic [SLOTS-1:0] mask,
    output slot_idx_t        idx,
    output logic             any
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = SLOT_IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lmg_seq.sv
// Runs one LMG pass per start: launch, wait, drain the FIFO, stream valid moves.
module lmg_seq
    import lmg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [255:0]      bstate_in,
    input  logic              lcas_in,
    input  logic              rcas_in,
    input  logic [7:0]        enp_in,
    output logic              lmg_reset,
    output logic [255:0]      lmg_bstate,
    output logic              lmg_lcas,
    output logic              lmg_rcas,
    output logic [7:0]        lmg_enp,
    input  logic              lmg_done,
    output logic              lmg_rden,
    input  logic [WORD_W-1:0] lmg_fifo_out,
    input  logic              lmg_fifo_empty,
    lmg_seq_if.master         mv,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  move_count
);

    localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t           stateQ, stateD;
    logic [TO_W-1:0]  toCntQ, toCntD;
    slots_t           wordQ, wordD;
    logic [SLOTS-1:0] maskQ, maskD;
    logic [CNT_W-1:0] countQ, countD;
    logic             errQ, errD;
    logic             startAcc;
    slot_idx_t        pickIdx;
    logic             pickAny;
    move_t            curSlot;
    slots_t           fifoSlots;
    logic [WORD_W-SLOTS*MOVE_W-1:0] unusedFifoTop;
    logic             unusedInvalidBit;

    assign fifoSlots        = lmg_fifo_out[SLOTS*MOVE_W-1:0];
    assign unusedFifoTop    = lmg_fifo_out[WORD_W-1:SLOTS*MOVE_W];
    assign curSlot          = slot_get(wordQ, pickIdx);
    assign unusedInvalidBit = curSlot[MV_INVALID_BIT];
    assign startAcc         = (stateQ == StIdle) && start;

    assign lmg_reset  = (stateQ == StIdle) || (stateQ == StLaunch) || (stateQ == StFinish);
    assign busy       = (stateQ != StIdle);
    assign done       = (stateQ == StFinish);
    assign err        = errQ;
    assign move_count = countQ;

    lmg_slot_pick u_pick (
        .mask (maskQ),
        .idx  (pickIdx),
        .any  (pickAny)
    );

    // Next-state, datapath updates and stream/FIFO strobes.
    always_comb begin
        stateD      = stateQ;
        toCntD      = toCntQ;
        wordD       = wordQ;
        maskD       = maskQ;
        countD      = countQ;
        errD        = errQ;
        lmg_rden    = 1'b0;
        mv.mv_valid = 1'b0;
        mv.mv_data  = '0;

        unique case (stateQ)
            StIdle: begin
                if (start) begin
                    countD = '0;
                    errD   = 1'b0;
                    stateD = StLaunch;
                end
            end
            StLaunch: begin
                toCntD = '0;
                stateD = StWaitDone;
            end
            StWaitDone: begin
                if (lmg_done) begin
                    stateD = StPop;
                end else if (toCntQ == TO_W'(TIMEOUT_CYC - 1)) begin
                    errD   = 1'b1;
                    stateD = StFinish;
                end else begin
                    toCntD = toCntQ + 1'b1;
                end
            end
            StPop: begin
                if (lmg_fifo_empty) begin
                    stateD = StFinish;
                end else begin
                    lmg_rden = 1'b1;
                    stateD   = StCapture;
                end
            end
            StCapture: begin
                wordD = fifoSlots;
                for (int i = 0; i < SLOTS; i++) begin
                    maskD[i] = ~fifoSlots[SLOTS-1-i][MV_INVALID_BIT];
                end
                stateD = StEmit;
            end
            StEmit: begin
                if (!pickAny) begin
                    stateD = StPop;
                end else begin
                    mv.mv_valid = 1'b1;
                    mv.mv_data[PASS_LSB +: PASS_W] = curSlot[PASS_LSB +: PASS_W];
                    mv.mv_data[FROM_LSB +: SQ_W]   = curSlot[FROM_LSB +: SQ_W];
                    mv.mv_data[TO_LSB +: SQ_W]     = curSlot[TO_LSB +: SQ_W];
                    if (mv.mv_ready) begin
                        maskD = maskQ & ~(SLOTS'(1) << pickIdx);
                        if (countQ != '1) begin
                            countD = countQ + 1'b1;
                        end
                        // Leave straight after the last beat to save a cycle per word.
                        if (maskD == '0) begin
                            stateD = StPop;
                        end
                    end
                end
            end
            StFinish: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    // State and latched LMG inputs; reset aborts any pass in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ     <= StIdle;
            toCntQ     <= '0;
            wordQ      <= '0;
            maskQ      <= '0;
            countQ     <= '0;
            errQ       <= 1'b0;
            lmg_bstate <= '0;
            lmg_lcas   <= 1'b0;
            lmg_rcas   <= 1'b0;
            lmg_enp    <= '0;
        end else begin
            stateQ <= stateD;
            toCntQ <= toCntD;
            wordQ  <= wordD;
            maskQ  <= maskD;
            countQ <= countD;
            errQ   <= errD;
            if (startAcc) begin
                lmg_bstate <= bstate_in;
                lmg_lcas   <= lcas_in;
                lmg_rcas   <= rcas_in;
                lmg_enp    <= enp_in;
            end
        end
    end

endmodule

// File: doc/lmg_seq.md
Name: lmg_seq

Overview:
- Sequencer that runs one LMG (legal move generator) pass per request.
- Latches the board state and castling/en-passant flags, then pulses the LMG reset and waits for LMG done.
- Drains the LMG output FIFO (8 move slots per 160-bit word), drops invalid slots and emits valid 19-bit moves one per beat on a valid/ready stream to the search engine.
- Reports the move count, completion and timeout error.

Parameters:
- TIMEOUT_CYC, 4096, max cycles in WAIT_DONE before declaring error
- CNT_W, 8, width of move_count; count saturates at 2^CNT_W-1

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  one-cycle request; sampled only in IDLE
- bstate_in  in  256  board state, latched on accepted start
- lcas_in, rcas_in  in  1 each  castling flags, latched on start
- enp_in  in  8  en-passant flags, latched on start
- lmg_reset  out  1  reset to LMG (high = held in reset)
- lmg_bstate  out  256  latched board state to LMG
- lmg_lcas, lmg_rcas  out  1 each  latched castling flags
- lmg_enp  out  8  latched en-passant flags
- lmg_done  in  1  LMG generation complete (level)
- lmg_rden  out  1  FIFO pop strobe
- lmg_fifo_out  in  160  FIFO word; slot k (k=1..8) = bits [151-19(k-1) -: 19]; bits [159:152] ignored
- lmg_fifo_empty  in  1  FIFO empty
- mv_valid  out  1  move beat valid
- mv_data  out  19  move: [18]=0 always; [11:6] from square; [5:0] to square; [17:12] passed through
- mv_ready  in  1  downstream accepts beat
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of pass
- err  out  1  timeout flag; valid with done, held until next accepted start
- move_count  out  CNT_W  valid moves emitted this pass; held until next accepted start

Behaviour:
- Reset values:
  - lmg_reset=1; lmg_rden=0; mv_valid=0; mv_data=0; busy=0; done=0; err=0; move_count=0.
  - lmg_bstate=0; lmg_lcas=0; lmg_rcas=0; lmg_enp=0.
- The reset input aborts any pass mid-operation. The partial stream is discarded and no done is produced.
- FIFO read latency: lmg_rden high in cycle t with lmg_fifo_empty=0 → word on lmg_fifo_out in cycle t+1.
- FSM states: IDLE, LAUNCH, WAIT_DONE, POP, CAPTURE, EMIT, FINISH.
- IDLE:
  - lmg_reset=1.
  - On start: latch inputs, clear move_count and err, go to LAUNCH.
- LAUNCH: hold lmg_reset=1 for exactly 1 cycle with new inputs stable → WAIT_DONE.
- WAIT_DONE:
  - lmg_reset=0; timeout counter increments.
  - lmg_done=1 → POP.
  - Counter reaches TIMEOUT_CYC → err=1, go to FINISH.
- POP:
  - If lmg_fifo_empty=1 → FINISH.
  - Otherwise assert lmg_rden for 1 cycle → CAPTURE.
- CAPTURE: register the word; remaining-mask[k] = ~slot_k[18] → EMIT.
- EMIT:
  - Priority select the lowest k with mask set. Slot 1 goes first, so word order is preserved.
  - Invalid slots cost zero cycles.
  - If the mask is all-zero (including an all-invalid word) → POP.
  - Otherwise drive mv_valid=1 with mv_data=slot_k.
  - On mv_valid&&mv_ready: clear mask[k] and increment move_count (saturating). The next slot may be presented in the following cycle, giving 1 move/cycle under constant ready.
  - mv_data stays stable while mv_valid=1 and mv_ready=0.
- FINISH:
  - done=1 for 1 cycle; lmg_reset=1 → IDLE.
  - A start in the same cycle as done is ignored.
- start while busy=1: ignored, no latching.
- lmg_done already high on entry to WAIT_DONE (stale): not possible, because LAUNCH resets the LMG. lmg_done is sampled only from the cycle after LAUNCH.
- Empty FIFO immediately after done → FINISH with move_count=0 and no beats.
- lmg_rden is never asserted while lmg_fifo_empty=1 or outside POP.
- Throughput target: ≤2 overhead cycles per FIFO word (POP+CAPTURE).

Decomposition:
- Shared package lmg_pkg:
  - MOVE_W=19, SLOTS=8, WORD_W=160, MV_INVALID_BIT=18
  - from/to field ranges, slot extraction function
  - FSM state enum
- Sub-module lmg_slot_pick: combinational 8-bit lowest-set priority select → index + any.
  - Reused by the future multi-LMG arbiter.

Test Plan:
- Start with LMG model giving 2 words: word1 slots 1,3,8 valid, word2 slot 2 valid, ready=1 → 4 beats in order 1,3,8,2; move_count=4; done 1 pulse; err=0.
- Same stimulus with mv_ready toggling 1-0-1-0 → mv_data stable during stalls; same 4 moves; move_count=4.
- Word of 8 invalid slots followed by an empty FIFO → no mv_valid; done with move_count=0; exactly 1 lmg_rden pulse.
- LMG never asserts done, TIMEOUT_CYC=16 → done 17-18 cycles after LAUNCH with err=1; lmg_rden never asserted.
- Start pulsed again during EMIT; then reset asserted mid-stream → second start ignored; after reset: outputs at reset values, busy=0, no done.
- Full board (initial position, 20 moves over 3 words) with lcas/rcas=1, enp=8'hff → lmg_bstate/flags equal the latched inputs through the pass; lmg_reset high exactly in LAUNCH/FINISH/IDLE; move_count=20.
